// File: rtl/fc_score_accumulator.sv
// Final-layer score accumulator: sums N_TERMS streamed Q8.8 terms per class on top of a
// per-class bias, with saturation, and presents the IC-entry score vector via valid/ready.
module fc_score_accumulator #(
  parameter int IC      = 10,
  parameter int N_TERMS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] bias_i [0:IC-1],
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [15:0] in_data_i,
  output logic signed [15:0] scores_o [0:IC-1],
  output logic               scores_valid_o,
  input  logic               scores_ready_i,
  output logic               sat_flag_o
);

  localparam int TW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int CW = (IC > 1) ? $clog2(IC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(N_TERMS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IC - 1);

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_e;

  // Returns {saturated, result}: 17-bit signed add clamped to the Q8.8 range.
  function automatic logic [16:0] sat_add(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) begin
      return {1'b1, (sum[16] ? 16'h8000 : 16'h7FFF)};
    end else begin
      return {1'b0, sum[15:0]};
    end
  endfunction

  state_e             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [CW-1:0]      c_q, c_d;
  logic signed [15:0] acc_q, acc_d;
  logic               sat_q, sat_d;
  logic signed [15:0] scores_q [0:IC-1];
  logic signed [15:0] scores_d [0:IC-1];
  logic signed [15:0] base_s;
  logic [16:0]        add_s;

  // State, counters, accumulator and score registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      t_q     <= {TW{1'b0}};
      c_q     <= {CW{1'b0}};
      acc_q   <= 16'sd0;
      sat_q   <= 1'b0;
      for (int c = 0; c < IC; c++) begin
        scores_q[c] <= 16'sd0;
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      scores_q <= scores_d;
    end
  end

  // Next-state: the first term of each class seeds from its bias instead of the running sum.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    c_d      = c_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    scores_d = scores_q;
    base_s   = (t_q == {TW{1'b0}}) ? bias_i[c_q] : acc_q;
    add_s    = sat_add(base_s, in_data_i);
    case (state_q)
      ST_ACCUM: begin
        if (in_valid_i) begin
          acc_d = add_s[15:0];
          if (add_s[16]) begin
            sat_d = 1'b1;
          end else begin
            sat_d = sat_q;
          end
          if (t_q == T_LAST) begin
            scores_d[c_q] = add_s[15:0];
            t_d           = {TW{1'b0}};
            if (c_q == C_LAST) begin
              c_d     = {CW{1'b0}};
              state_d = ST_HOLD;
            end else begin
              c_d     = c_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            t_d = t_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (scores_ready_i) begin
          state_d = ST_ACCUM;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  assign in_ready_o     = (state_q == ST_ACCUM);
  assign scores_valid_o = (state_q == ST_HOLD);
  assign sat_flag_o     = sat_q;
  assign scores_o       = scores_q;

endmodule

// File: tb/tb_fc_score_accumulator.sv
// Randomised self-checking bench for fc_score_accumulator against a per-frame arithmetic model.
module tb_fc_score_accumulator;

  localparam int IC = 10;
  localparam int NT = 4;
  localparam int NTOT = IC * NT;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] bias [0:IC-1];
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic signed [15:0] scores [0:IC-1];
  logic               scores_valid;
  logic               scores_ready;
  logic               sat_flag;

  logic signed [15:0] terms [0:NTOT-1];
  logic [15:0]        exp_scores [0:IC-1];
  logic               exp_sat;
  int                 n_checks = 0;
  int                 n_errors = 0;

  fc_score_accumulator #(.IC(IC), .N_TERMS(NT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bias_i         (bias),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .scores_o       (scores),
    .scores_valid_o (scores_valid),
    .scores_ready_i (scores_ready),
    .sat_flag_o     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each class starts at its bias, adds NT terms, clamping after every add.
  task automatic model_frame();
    int acc;
    exp_sat = 1'b0;
    for (int c = 0; c < IC; c++) begin
      acc = int'(bias[c]);
      for (int k = 0; k < NT; k++) begin
        acc = acc + int'(terms[c*NT + k]);
        if (acc > 32767) begin
          acc = 32767;
          exp_sat = 1'b1;
        end else if (acc < -32768) begin
          acc = -32768;
          exp_sat = 1'b1;
        end
      end
      exp_scores[c] = 16'(acc);
    end
  endtask

  task automatic check_zero_state(input string tag);
    for (int c = 0; c < IC; c++) check_eq({tag, "_score"}, {16'h0, scores[c]}, 32'h0);
    check_eq({tag, "_valid"}, {31'h0, scores_valid}, 32'h0);
    check_eq({tag, "_sat"}, {31'h0, sat_flag}, 32'h0);
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input int hold_cycles);
    int  idx = 0;
    int  budget = 0;
    int  rdy_cnt = 0;
    bit  stable;
    logic [15:0] snap [0:IC-1];
    model_frame();
    while (idx < NTOT && budget < 2000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = terms[idx];
      if (in_ready) rdy_cnt++;
      if (in_valid && in_ready) idx++;
      budget++;
    end
    if (idx < NTOT) begin
      check_eq({tag, "_timeout"}, 32'(idx), 32'(NTOT));
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = 16'($urandom);
    scores_ready = 1'b0;
    check_eq({tag, "_valid_latency"}, {31'h0, scores_valid}, 32'h1);
    check_eq({tag, "_ready_in_hold"}, {31'h0, in_ready}, 32'h0);
    check_eq({tag, "_sat"}, {31'h0, sat_flag}, {31'h0, exp_sat});
    if (gap_pct == 0) check_eq({tag, "_ready_cycles"}, 32'(rdy_cnt), 32'(NTOT));
    for (int c = 0; c < IC; c++) begin
      check_eq($sformatf("%s_score%0d", tag, c), {16'h0, scores[c]}, {16'h0, exp_scores[c]});
      snap[c] = scores[c];
    end
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      in_data = 16'($urandom);
      stable = 1'b1;
      for (int c = 0; c < IC; c++) if (scores[c] !== snap[c]) stable = 1'b0;
      check_eq({tag, "_hold_stable"}, {31'h0, stable}, 32'h1);
      check_eq({tag, "_hold_ctrl"}, {29'h0, scores_valid, in_ready, sat_flag},
               {29'h0, 1'b1, 1'b0, exp_sat});
    end
    scores_ready = 1'b1;
    @(negedge clk);
    scores_ready = 1'b0;
    in_valid     = 1'b0;
    check_eq({tag, "_ready_after_hs"}, {31'h0, in_ready}, 32'h1);
    check_eq({tag, "_valid_after_hs"}, {31'h0, scores_valid}, 32'h0);
    check_eq({tag, "_sat_after_hs"}, {31'h0, sat_flag}, 32'h0);
    stable = 1'b1;
    for (int c = 0; c < IC; c++) if (scores[c] !== snap[c]) stable = 1'b0;
    check_eq({tag, "_scores_kept"}, {31'h0, stable}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 16'sd0;
    scores_ready = 1'b0;
    for (int c = 0; c < IC; c++) bias[c] = 16'sd0;
    repeat (3) @(negedge clk);
    check_zero_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_in_ready", {31'h0, in_ready}, 32'h1);

    // Basic frame: all terms 1.0, no bias.
    for (int i = 0; i < NTOT; i++) terms[i] = 16'sh0100;
    run_frame("basic", 0, 0);

    // Bias and class ordering.
    for (int c = 0; c < IC; c++) bias[c] = (c == 3) ? 16'shFF00 : 16'sh0000;
    for (int i = 0; i < NTOT; i++) terms[i] = 16'(16'h0080 * ((i / NT) + 1));
    run_frame("order", 0, 1);

    // Positive and negative saturation.
    for (int c = 0; c < IC; c++) bias[c] = 16'sd0;
    for (int i = 0; i < NTOT; i++) terms[i] = 16'($urandom_range(511)) - 16'sd256;
    for (int k = 0; k < NT; k++) begin
      terms[k]      = 16'sh7000;
      terms[NT + k] = 16'sh9000;
    end
    run_frame("sat", 0, 2);

    // Backpressure: same frame gap-free and then with gaps and a 5-cycle hold.
    for (int c = 0; c < IC; c++) bias[c] = 16'($urandom_range(4095)) - 16'sd2048;
    for (int i = 0; i < NTOT; i++) terms[i] = 16'($urandom_range(8191)) - 16'sd4096;
    run_frame("nogap", 0, 0);
    run_frame("bp", 40, 5);

    // Mid-frame reset after 17 accepted terms.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'sh3000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_zero_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    for (int c = 0; c < IC; c++) bias[c] = 16'sd0;
    for (int i = 0; i < NTOT; i++) terms[i] = 16'sh0100;
    run_frame("post_rst", 0, 0);

    // Random full-range frames with random gaps and hold lengths.
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < IC; c++) bias[c] = 16'($urandom);
      for (int i = 0; i < NTOT; i++) terms[i] = 16'($urandom);
      run_frame($sformatf("rnd%0d", f), $urandom_range(50), $urandom_range(4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_score_accumulator.md
# fc_score_accumulator

Collects the streamed Q8.8 partial products of the final fully-connected layer, adds a per-class bias, and assembles the complete class-score vector for the argmax comparator. It is the producer side of the score-vector interface: terms arrive one per handshake in class-major order, and a finished vector of IC signed Q8.8 scores is held with a valid/ready handshake until the downstream comparator stage accepts it.

## Interface
- IC, 10, number of classes (score-vector length); IC ≥ 2
- N_TERMS, 64, terms accumulated per class; N_TERMS ≥ 1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bias  in  signed 16 × [0:IC-1]  per-class Q8.8 bias, held static during operation
- in_valid  in  1  in_data carries a term
- in_ready  out  1  block accepts a term this cycle
- in_data  in  signed 16  Q8.8 term
- scores  out  signed 16 × [0:IC-1]  assembled Q8.8 class scores
- scores_valid  out  1  scores holds a complete frame
- scores_ready  in  1  downstream accepts the frame
- sat_flag  out  1  at least one saturation occurred in the presented frame

## Operation
- Reset (rst_n low, asynchronous): state = ACCUM, term counter = 0, class counter = 0, acc = 0, every scores[c] = 0, scores_valid = 0, sat_flag = 0; in_ready = 1 once reset is released.
- Term order: N_TERMS terms for class 0, then N_TERMS for class 1, …, class IC-1. Class index is implied by position only.
- Term accepted when in_valid && in_ready.
- States:
  - ACCUM: in_ready = 1, scores_valid = 0.
  - HOLD: in_ready = 0, scores_valid = 1.
- ACCUM, on accept with term counter t and class counter c:
  - t = 0: acc ← sat(bias[c] + in_data). Otherwise acc ← sat(acc + in_data).
  - t = N_TERMS-1: scores[c] ← the same saturated result, t ← 0, c ← c+1. Otherwise t ← t+1.
  - With t = N_TERMS-1 and c = IC-1: c ← 0 and the state moves to HOLD.
  - Any saturation sets sat_flag (sticky for the frame).
- HOLD, on scores_valid && scores_ready: the state moves to ACCUM and sat_flag clears. scores keeps its values until overwritten class by class in the next frame.
- The bias for class c is added exactly once per frame, at that class's first term.
- N_TERMS = 1: each term both seeds and finishes its class, so scores[c] = sat(bias[c] + term).
- Arithmetic: sign-extend both operands to 17 bits and add.
  - Result > 32767 gives 0x7FFF.
  - Result < -32768 gives 0x8000.
  - Otherwise take the low 16 bits.
  - No rounding; Q8.8 alignment is preserved (plain integer add).
- Counter widths: $clog2(N_TERMS) and $clog2(IC), minimum 1 bit.

## Timing
- in_ready and scores_valid are decoded from the registered state only. Neither depends combinationally on in_valid or scores_ready.
- Latency: scores_valid rises the cycle after the handshake of the final term (term IC·N_TERMS). scores is fully updated in that same cycle.
- Throughput: one term per cycle in ACCUM. A frame takes at least IC·N_TERMS cycles, plus ≥1 HOLD cycle.
- Back-to-back: if scores_ready is high on the first HOLD cycle, in_ready returns the next cycle. This gives one bubble cycle between frames.
- in_valid low in ACCUM: no state change.
- in_valid high in HOLD: ignored and not consumed. The upstream stage must keep the term until in_ready.
- scores, scores_valid and sat_flag are stable for the whole of HOLD, regardless of in_valid.
- Reset mid-frame discards the partial frame. The next frame starts at class 0, term 0.
- Changing bias mid-frame is unsupported. A class's bias is sampled only at its first term.

## Test plan
- Reset: assert rst_n low mid-stream → all scores 0x0000, scores_valid 0, sat_flag 0, in_ready 1 after release.
- Basic frame (IC=10, N_TERMS=4, bias all 0, 40 terms of 0x0100, in_valid held high) → all scores 0x0400 and sat_flag 0. scores_valid goes high exactly 1 cycle after the 40th handshake. in_ready is high for exactly 40 cycles.
- Bias and ordering: bias[3]=0xFF00, other biases 0, class c terms = 0x0080·(c+1) → scores[3] = 0x0700, scores[c≠3] = 0x0200·(c+1). Class mapping is confirmed.
- Saturation: class 0 terms 0x7000 ×4 → scores[0]=0x7FFF. Class 1 terms 0x9000 ×4 → scores[1]=0x8000. sat_flag 1 with scores_valid, cleared after the handshake.
- Backpressure: random in_valid gaps, scores_ready low for 5 HOLD cycles, then high → same scores as the gap-free run. scores stable and in_ready 0 while held. in_ready 1 the cycle after the handshake. Terms offered during HOLD are not consumed.
- Mid-frame reset after 17 accepted terms, then a full frame of 0x0100 → scores all 0x0400 and no residue from the aborted frame.
